updown_counter: RTL and testbench

Parametrised successor to the fixed-width up/down PLC counter. It provides one counter of configurable width with three run modes (up, down, up/down) plus disabled. Count inputs are edge-detected, and it adds synchronous clear, preset load, and overflow/underflow flags. It sits in the timer/counter peripheral block and is driven by the instruction pipeline's counter-control outputs.

---
 rtl/updown_counter.sv | 145 ++++++++++++++
 tb/tb_updown_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Up/down counter with edge-detected count inputs, clear, preset load and sticky ov/un flags; acc updates on the input's first sampled edge.
// Define COUNTER_SATURATE_EN to clamp at 0 / max instead of wrapping.
module updown_counter #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             cu_in,
  input  logic             cd_in,
  input  logic             clr,
  input  logic             load,
  input  logic [ACC_W-1:0] preset,
  output logic [ACC_W-1:0] acc,
  output logic             dn,
  output logic             cu,
  output logic             cd,
  output logic             ov,
  output logic             un
);

  typedef enum logic [1:0] {
    DIS  = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    UPDN = 2'b11
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_cu_q;
  logic               r_cd_q;
  logic [ACC_W-1:0]   r_acc;
  logic               r_cu;
  logic               r_cd;
  logic               r_ov;
  logic               r_un;

  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_cu_nxt;
  logic               w_cd_nxt;
  logic               w_ov_nxt;
  logic               w_un_nxt;
  logic               w_up_ev;
  logic               w_dn_ev;
  logic               w_inc;
  logic               w_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DIS;
      r_cu_q  <= 1'b0;
      r_cd_q  <= 1'b0;
      r_acc   <= '0;
      r_cu    <= 1'b0;
      r_cd    <= 1'b0;
      r_ov    <= 1'b0;
      r_un    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cu_q  <= cu_in;
      r_cd_q  <= cd_in;
      r_acc   <= w_acc_nxt;
      r_cu    <= w_cu_nxt;
      r_cd    <= w_cd_nxt;
      r_ov    <= w_ov_nxt;
      r_un    <= w_un_nxt;
    end
  end

  always_comb begin
    w_state_nxt = state_t'(mode);
    w_up_ev     = cu_in & ~r_cu_q;
    w_dn_ev     = cd_in & ~r_cd_q;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_acc_nxt   = r_acc;
    w_cu_nxt    = 1'b0;
    w_cd_nxt    = 1'b0;
    w_ov_nxt    = r_ov;
    w_un_nxt    = r_un;

    // In UPDN simultaneous up and down events cancel out.
    case (r_state)
      UP:      w_inc = w_up_ev;
      DOWN:    w_dec = w_dn_ev;
      UPDN: begin
        w_inc = w_up_ev & ~w_dn_ev;
        w_dec = w_dn_ev & ~w_up_ev;
      end
      default: ;
    endcase

    if (clr) begin
      w_acc_nxt = (r_state == DOWN) ? preset : '0;
      w_ov_nxt  = 1'b0;
      w_un_nxt  = 1'b0;
    end else if (w_state_nxt != r_state) begin
      w_acc_nxt = (w_state_nxt == DOWN) ? preset : '0;
      w_ov_nxt  = 1'b0;
      w_un_nxt  = 1'b0;
    end else if (load) begin
      w_acc_nxt = preset;
    end else if (w_inc) begin
      w_cu_nxt = 1'b1;
      if (r_acc == ACC_MAX) begin
        w_ov_nxt = 1'b1;
`ifdef COUNTER_SATURATE_EN
        w_acc_nxt = ACC_MAX;
`else
        w_acc_nxt = '0;
`endif
      end else begin
        w_acc_nxt = r_acc + ACC_W'(1);
      end
    end else if (w_dec) begin
      w_cd_nxt = 1'b1;
      if (r_acc == '0) begin
        w_un_nxt = 1'b1;
`ifdef COUNTER_SATURATE_EN
        w_acc_nxt = '0;
`else
        w_acc_nxt = ACC_MAX;
`endif
      end else begin
        w_acc_nxt = r_acc - ACC_W'(1);
      end
    end

    case (r_state)
      DIS:     dn = 1'b0;
      DOWN:    dn = (r_acc == '0);
      default: dn = (r_acc >= preset);
    endcase
  end

  assign acc = r_acc;
  assign cu  = r_cu;
  assign cd  = r_cd;
  assign ov  = r_ov;
  assign un  = r_un;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter (ACC_W=8): directed scenarios plus random stimulus against a behavioural model.
module tb_updown_counter;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;
  localparam bit SAT  =
`ifdef COUNTER_SATURATE_EN
    1'b1;
`else
    1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic         cu_in, cd_in, clr, load;
  logic [W-1:0] preset;
  logic [W-1:0] acc;
  logic         dn, cu, cd, ov, un;

  int n_total = 0;
  int n_pass  = 0;

  updown_counter #(.ACC_W(W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .cu_in(cu_in), .cd_in(cd_in),
    .clr(clr), .load(load), .preset(preset), .acc(acc), .dn(dn),
    .cu(cu), .cd(cd), .ov(ov), .un(un)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     acc;
    bit [1:0] mode;
    bit     pu, pd, cu, cd, ov, un;
  } model_t;

  model_t m;

  function automatic model_t m_rst();
    model_t z;
    z.acc = 0; z.mode = 2'b00; z.pu = 0; z.pd = 0;
    z.cu = 0; z.cd = 0; z.ov = 0; z.un = 0;
    return z;
  endfunction

  // Next state from the counter's rules, as signed integer arithmetic.
  function automatic model_t m_next(model_t s);
    model_t n = s;
    bit up = cu_in && !s.pu;
    bit dv = cd_in && !s.pd;
    int delta = 0;
    n.cu = 0; n.cd = 0; n.mode = mode; n.pu = cu_in; n.pd = cd_in;
    if (clr) begin
      n.acc = (s.mode == 2) ? int'(preset) : 0;
      n.ov = 0; n.un = 0;
    end else if (mode != s.mode) begin
      n.acc = (mode == 2) ? int'(preset) : 0;
      n.ov = 0; n.un = 0;
    end else if (load) begin
      n.acc = int'(preset);
    end else begin
      if (s.mode == 1 || s.mode == 3) delta += int'(up);
      if (s.mode == 2 || s.mode == 3) delta -= int'(dv);
      if (delta != 0) begin
        if (delta > 0) n.cu = 1; else n.cd = 1;
        n.acc = s.acc + delta;
        if (n.acc > MAXV) begin
          n.ov = 1;
          n.acc = SAT ? MAXV : n.acc - (MAXV + 1);
        end
        if (n.acc < 0) begin
          n.un = 1;
          n.acc = SAT ? 0 : n.acc + (MAXV + 1);
        end
      end
    end
    return n;
  endfunction

  function automatic bit m_dn();
    case (m.mode)
      2'd0:    return 1'b0;
      2'd2:    return m.acc == 0;
      default: return m.acc >= int'(preset);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= m_rst();
    else       m <= m_next(m);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("acc", acc, m.acc);
    chk("dn",  dn,  m_dn());
    chk("cu",  cu,  m.cu);
    chk("cd",  cd,  m.cd);
    chk("ov",  ov,  m.ov);
    chk("un",  un,  m.un);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic pin_acc(input string name, input int exp);
    chk({name, "_dut"},   acc,   exp);
    chk({name, "_model"}, m.acc, exp);
  endtask

  task automatic pulse_up();
    cu_in = 1; tick(); cu_in = 0; tick();
  endtask

  task automatic pulse_dn();
    cd_in = 1; tick(); cd_in = 0; tick();
  endtask

  initial begin
    reset = 1; mode = 0; cu_in = 0; cd_in = 0; clr = 0; load = 0; preset = 0;
    #12;
    chk("reset_acc", acc, 0);
    chk("reset_dn",  dn,  0);
    chk("reset_ov",  ov,  0);
    reset = 0;
    tick();

    // UP, preset 3: four pulses count 1..4, dn from 3 onward
    preset = 3; mode = 1; tick();
    pin_acc("up_mchg", 0);
    for (int k = 1; k <= 4; k++) begin
      cu_in = 1; tick();
      pin_acc("up_cnt", k);
      chk("up_cu_pulse", cu, 1);
      chk("up_dn", dn, (k >= 3) ? 1 : 0);
      cu_in = 0; tick();
      chk("up_cu_low", cu, 0);
    end

    // DOWN, preset 5: held input decrements once, then four pulses to 0
    preset = 5; mode = 2; tick();
    pin_acc("dn_mchg", 5);
    cd_in = 1;
    for (int k = 0; k < 10; k++) tick();
    pin_acc("dn_held", 4);
    cd_in = 0; tick();
    for (int k = 0; k < 4; k++) pulse_dn();
    pin_acc("dn_zero", 0);
    chk("dn_done", dn, 1);

    // UPDN at 10: simultaneous events cancel, lone down gives 9
    mode = 3; tick();
    preset = 10; load = 1; tick(); load = 0;
    pin_acc("ud_load", 10);
    cu_in = 1; cd_in = 1; tick();
    pin_acc("ud_cancel", 10);
    chk("ud_cancel_cu", cu, 0);
    chk("ud_cancel_cd", cd, 0);
    cu_in = 0; cd_in = 0; tick();
    pulse_dn();
    pin_acc("ud_dec", 9);

    // UP overflow at 255, then clear
    mode = 1; tick();
    preset = 8'd255; load = 1; tick(); load = 0;
    pin_acc("ov_load", 255);
    pulse_up();
    pin_acc("ov_step", SAT ? 255 : 0);
    chk("ov_set", ov, 1);
    clr = 1; tick(); clr = 0;
    pin_acc("ov_clr", 0);
    chk("ov_cleared", ov, 0);

    // DOWN: clr beats load and a down event, then load alone
    preset = 3; mode = 2; tick();
    pin_acc("pri_start", 3);
    preset = 9; clr = 1; load = 1; cd_in = 1; tick();
    pin_acc("pri_clr", 9);
    chk("pri_cd", cd, 0);
    clr = 0; load = 0; cd_in = 0; tick();
    pulse_dn();
    pin_acc("pri_dec", 8);
    load = 1; tick(); load = 0;
    pin_acc("pri_load", 9);

    // Reset mid-count in UPDN at 7
    mode = 3; tick();
    preset = 7; load = 1; tick(); load = 0;
    pin_acc("rst_pre", 7);
    #1 reset = 1;
    #1;
    chk("rst_acc", acc, 0);
    chk("rst_dn",  dn,  0);
    chk("rst_ov",  ov,  0);
    tick();
    reset = 0;
    tick();
    pin_acc("rst_reinit", 0);
    cu_in = 1; tick();
    pin_acc("rst_count", 1);
    cu_in = 0; tick();

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      cu_in = 1'($urandom_range(1));
      cd_in = 1'($urandom_range(1));
      clr   = ($urandom_range(31) == 0);
      load  = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0:       preset = 8'd0;
          1:       preset = 8'd255;
          2:       preset = 8'($urandom_range(2) + 253);
          default: preset = 8'($urandom_range(255));
        endcase
      end
      reset = ($urandom_range(499) == 0);
      tick();
    end
    reset = 0; cu_in = 0; cd_in = 0; clr = 0; load = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
